// File: rtl/lpcm_pkg.sv
// Shared types and helpers for the multi-channel LPCM monitor.
// Frames travel as flat vectors {latency lanes, sample lanes, mask} so widths follow the parameters.
package lpcm_pkg;

  localparam int LPCM_MAX_CH     = 8;
  localparam int LPCM_MAX_DATA_W = 32;
  localparam int LPCM_MAX_CNT_W  = 32;

  // Widest frame, for tools and benches that want named fields; the RTL uses flat vectors.
  typedef struct packed {
    logic [LPCM_MAX_CH-1:0][LPCM_MAX_CNT_W-1:0]  latency;
    logic [LPCM_MAX_CH-1:0][LPCM_MAX_DATA_W-1:0] sample;
    logic [LPCM_MAX_CH-1:0]                      mask;
  } lpcm_frame_t;

  function automatic int frame_w(input int nch, input int dw, input int cw);
    return nch * (1 + dw + cw);
  endfunction

  // Increment that sticks at the all-ones value of the given width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
    logic [31:0] top;
    top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (cnt >= top) ? top : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/lpcm_multi_monitor_if.sv
// Frame output stream of the LPCM monitor: valid/ready plus the frame payload.
interface lpcm_multi_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
) ();

  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH-1:0]        out_mask;
  logic [NUM_CH*DATA_W-1:0] out_sample;
  logic [NUM_CH*CNT_W-1:0]  out_latency;

  modport master (
    output out_valid,
    output out_mask,
    output out_sample,
    output out_latency,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_mask,
    input  out_sample,
    input  out_latency,
    output out_ready
  );

endinterface

// File: rtl/lpcm_mon_fifo.sv
// Generic register FIFO with extra-bit pointers; a pop frees a slot for a push in the same cycle.
module lpcm_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en    = pop && !empty && !clear;
  assign wr_en    = push && !clear && (!full || rd_en);
  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (wr_en) wr_d = wr_q + (AW+1)'(1);
    if (rd_en) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/lpcm_multi_monitor.sv
// Multi-channel LPCM monitor: per-channel inter-sample latency, framed into a backpressured FIFO,
// with per-channel max-latency statistics and drop accounting.
module lpcm_multi_monitor
  import lpcm_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 24,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  lpcm_multi_monitor_if.master     out_if,
  output logic [NUM_CH*CNT_W-1:0]  max_latency,
  output logic [15:0]              drop_count,
  output logic                     overflow
);

  localparam int FRAME_W  = frame_w(NUM_CH, DATA_W, CNT_W);
  localparam int SAMP_LSB = NUM_CH;
  localparam int LAT_LSB  = NUM_CH + NUM_CH * DATA_W;

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] max_q, max_d;
  logic [NUM_CH-1:0][CNT_W-1:0] lat;
  logic [NUM_CH-1:0]            first_q, first_d;
  logic [15:0]                  drop_q, drop_d;
  logic                         ovf_q, ovf_d;

  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] head;
  logic               push, pop, full, empty, drop;

  // A lane's latency is its counter before this cycle's update, or 0 until its first strobe.
  always_comb begin
    cnt_d   = cnt_q;
    first_d = first_q;
    max_d   = max_q;
    lat     = '0;
    frame   = '0;
    frame[NUM_CH-1:0] = ch_en;
    for (int i = 0; i < NUM_CH; i++) begin
      lat[i] = first_q[i] ? '0 : cnt_q[i];
      if (ch_en[i]) begin
        cnt_d[i]   = '0;
        first_d[i] = 1'b0;
        frame[SAMP_LSB + i*DATA_W +: DATA_W] = ch_data[i*DATA_W +: DATA_W];
        frame[LAT_LSB + i*CNT_W +: CNT_W]    = lat[i];
        if (lat[i] > max_q[i]) max_d[i] = lat[i];
      end else begin
        cnt_d[i] = CNT_W'(sat_inc(32'(cnt_q[i]), CNT_W));
      end
    end
  end

  assign push   = (|ch_en) && !clear;
  assign pop    = !empty && out_if.out_ready && !clear;
  assign drop   = push && full && !pop;
  assign drop_d = drop ? 16'(sat_inc(32'(drop_q), 16)) : drop_q;
  assign ovf_d  = ovf_q | drop;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q   <= '0;
      first_q <= '1;
      max_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      first_q <= '1;
      max_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
      max_q   <= max_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  lpcm_mon_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .clear     (clear),
    .push      (push),
    .push_data (frame),
    .full      (full),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty)
  );

  // Head register is gated by empty so an idle output reads as all zeros.
  assign out_if.out_valid   = !empty;
  assign out_if.out_mask    = empty ? '0 : head[NUM_CH-1:0];
  assign out_if.out_sample  = empty ? '0 : head[SAMP_LSB +: NUM_CH*DATA_W];
  assign out_if.out_latency = empty ? '0 : head[LAT_LSB +: NUM_CH*CNT_W];

  assign max_latency = max_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_lpcm_multi_monitor.sv
// Directed bench for lpcm_multi_monitor: vector table for latency framing plus
// hand sequences for backpressure, drops, clear, async reset and counter saturation.
module tb_lpcm_multi_monitor;

  logic        clk;
  logic        resetb;
  logic        clear;
  logic [1:0]  chEn;
  logic [47:0] chData;
  logic [31:0] maxLatency;
  logic [15:0] dropCount;
  logic        overflow;
  logic [7:0]  maxLatency4;
  logic [15:0] dropCount4;
  logic        overflow4;

  int checkCount = 0;
  int passCount  = 0;

  lpcm_multi_monitor_if #(.NUM_CH(2), .DATA_W(24), .CNT_W(16)) outIf ();
  lpcm_multi_monitor_if #(.NUM_CH(2), .DATA_W(24), .CNT_W(4))  outIf4 ();

  lpcm_multi_monitor #(.NUM_CH(2), .DATA_W(24), .CNT_W(16), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .resetb      (resetb),
    .clear       (clear),
    .ch_en       (chEn),
    .ch_data     (chData),
    .out_if      (outIf),
    .max_latency (maxLatency),
    .drop_count  (dropCount),
    .overflow    (overflow)
  );

  lpcm_multi_monitor #(.NUM_CH(2), .DATA_W(24), .CNT_W(4), .FIFO_DEPTH(8)) dut4 (
    .clk         (clk),
    .resetb      (resetb),
    .clear       (clear),
    .ch_en       (chEn),
    .ch_data     (chData),
    .out_if      (outIf4),
    .max_latency (maxLatency4),
    .drop_count  (dropCount4),
    .overflow    (overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [23:0] d0;
    logic [23:0] d1;
    logic        expValid;
    logic [1:0]  expMask;
    logic [23:0] expS0;
    logic [23:0] expS1;
    logic [15:0] expL0;
    logic [15:0] expL1;
    logic [15:0] expM0;
    logic [15:0] expM1;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic [23:0] d0, input logic [23:0] d1,
                               input logic ready);
    chEn            = en;
    chData          = {d1, d0};
    outIf.out_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    #2 resetb = 1'b0;
    #2 resetb = 1'b1;
    tick();
  endtask

  // Watchdog keeps the run bounded whatever the DUT does.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] drainExp [8];

    vecs[0]  = '{2'b01, 24'h123456, 24'h0,      1'b1, 2'b01, 24'h123456, 24'h0,      16'd0, 16'd0, 16'd0, 16'd0};
    vecs[1]  = '{2'b01, 24'h0000AA, 24'h0,      1'b1, 2'b01, 24'h0000AA, 24'h0,      16'd0, 16'd0, 16'd0, 16'd0};
    vecs[2]  = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd0, 16'd0};
    vecs[3]  = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd0, 16'd0};
    vecs[4]  = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd0, 16'd0};
    vecs[5]  = '{2'b01, 24'h555555, 24'h0,      1'b1, 2'b01, 24'h555555, 24'h0,      16'd3, 16'd0, 16'd3, 16'd0};
    vecs[6]  = '{2'b10, 24'h999999, 24'hABCDEF, 1'b1, 2'b10, 24'h0,      24'hABCDEF, 16'd0, 16'd0, 16'd3, 16'd0};
    vecs[7]  = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd3, 16'd0};
    vecs[8]  = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd3, 16'd0};
    vecs[9]  = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd3, 16'd0};
    vecs[10] = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd3, 16'd0};
    vecs[11] = '{2'b11, 24'h111111, 24'h222222, 1'b1, 2'b11, 24'h111111, 24'h222222, 16'd5, 16'd4, 16'd5, 16'd4};
    vecs[12] = '{2'b00, 24'h0,      24'h0,      1'b0, 2'b00, 24'h0,      24'h0,      16'd0, 16'd0, 16'd5, 16'd4};

    drainExp = '{24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'h77};

    // Reset state
    resetb           = 1'b0;
    clear            = 1'b0;
    outIf4.out_ready = 1'b1;
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    checkOutput("reset valid",    outIf.out_valid,   0);
    checkOutput("reset mask",     outIf.out_mask,    0);
    checkOutput("reset sample",   outIf.out_sample,  0);
    checkOutput("reset latency",  outIf.out_latency, 0);
    checkOutput("reset max",      maxLatency,        0);
    checkOutput("reset drops",    dropCount,         0);
    checkOutput("reset overflow", overflow,          0);

    // Latency framing table, sink always ready
    for (int k = 0; k < 13; k++) begin
      applyStimulus(vecs[k].en, vecs[k].d0, vecs[k].d1, 1'b1);
      tick();
      checkOutput($sformatf("vec%0d valid", k), outIf.out_valid,           vecs[k].expValid);
      checkOutput($sformatf("vec%0d mask", k),  outIf.out_mask,            vecs[k].expMask);
      checkOutput($sformatf("vec%0d s0", k),    outIf.out_sample[23:0],    vecs[k].expS0);
      checkOutput($sformatf("vec%0d s1", k),    outIf.out_sample[47:24],   vecs[k].expS1);
      checkOutput($sformatf("vec%0d lat0", k),  outIf.out_latency[15:0],   vecs[k].expL0);
      checkOutput($sformatf("vec%0d lat1", k),  outIf.out_latency[31:16],  vecs[k].expL1);
      checkOutput($sformatf("vec%0d max0", k),  maxLatency[15:0],          vecs[k].expM0);
      checkOutput($sformatf("vec%0d max1", k),  maxLatency[31:16],         vecs[k].expM1);
    end

    // Backpressure: 10 strobes into an 8-deep FIFO
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b0);
    pulseReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b01, 24'(i + 1), 24'h0, 1'b0);
      tick();
    end
    checkOutput("fill drops",    dropCount,              2);
    checkOutput("fill overflow", overflow,               1);
    checkOutput("fill valid",    outIf.out_valid,        1);
    checkOutput("fill head",     outIf.out_sample[23:0], 1);
    checkOutput("fill lat0",     outIf.out_latency[15:0], 0);

    // Full FIFO with push and pop together: no drop
    applyStimulus(2'b01, 24'h77, 24'h0, 1'b1);
    tick();
    checkOutput("pushpop drops", dropCount,              2);
    checkOutput("pushpop head",  outIf.out_sample[23:0], 2);

    applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
    for (int j = 0; j < 8; j++) begin
      checkOutput($sformatf("drain%0d sample", j), outIf.out_sample[23:0], drainExp[j]);
      checkOutput($sformatf("drain%0d mask", j),   outIf.out_mask,         2'b01);
      outIf.out_ready = 1'b0;
      tick();
      checkOutput($sformatf("stall%0d sample", j), outIf.out_sample[23:0], drainExp[j]);
      checkOutput($sformatf("stall%0d valid", j),  outIf.out_valid,        1);
      outIf.out_ready = 1'b1;
      tick();
    end
    checkOutput("drained valid", outIf.out_valid,   0);
    checkOutput("drained max0",  maxLatency[15:0],  0);

    // Clear with three frames queued and ch1 strobing in the clear cycle
    applyStimulus(2'b10, 24'h0, 24'h11, 1'b0);
    tick();
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b0);
    tick();
    tick();
    applyStimulus(2'b10, 24'h0, 24'h22, 1'b0);
    tick();
    applyStimulus(2'b01, 24'h33, 24'h0, 1'b0);
    tick();
    checkOutput("preclear max1", maxLatency[31:16],       2);
    checkOutput("preclear head", outIf.out_sample[47:24], 24'h11);
    clear = 1'b1;
    applyStimulus(2'b10, 24'h0, 24'h44, 1'b1);
    tick();
    clear = 1'b0;
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
    checkOutput("clear valid",    outIf.out_valid, 0);
    checkOutput("clear mask",     outIf.out_mask,  0);
    checkOutput("clear drops",    dropCount,       0);
    checkOutput("clear overflow", overflow,        0);
    checkOutput("clear max",      maxLatency,      0);
    tick();
    tick();
    applyStimulus(2'b10, 24'h0, 24'h55, 1'b1);
    tick();
    checkOutput("postclear valid", outIf.out_valid,           1);
    checkOutput("postclear s1",    outIf.out_sample[47:24],   24'h55);
    checkOutput("postclear lat1",  outIf.out_latency[31:16],  0);

    // Async reset in the middle of a drain
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
    tick();
    applyStimulus(2'b10, 24'h0, 24'h66, 1'b0);
    tick();
    applyStimulus(2'b10, 24'h0, 24'h77, 1'b0);
    tick();
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b0);
    tick();
    applyStimulus(2'b10, 24'h0, 24'h88, 1'b0);
    tick();
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
    tick();
    checkOutput("middrain head", outIf.out_sample[47:24], 24'h77);
    checkOutput("middrain max1", maxLatency[31:16],       1);
    #2 resetb = 1'b0;
    #1;
    checkOutput("async valid", outIf.out_valid, 0);
    checkOutput("async mask",  outIf.out_mask,  0);
    checkOutput("async max",   maxLatency,      0);
    checkOutput("async drops", dropCount,       0);
    #1 resetb = 1'b1;
    tick();
    tick();
    applyStimulus(2'b10, 24'h0, 24'h99, 1'b1);
    tick();
    checkOutput("postreset valid", outIf.out_valid,          1);
    checkOutput("postreset lat1",  outIf.out_latency[31:16], 0);

    // Counter saturation: 20 idle cycles on a 4-bit and a 16-bit counter
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
    pulseReset();
    applyStimulus(2'b01, 24'hA0, 24'h0, 1'b1);
    tick();
    applyStimulus(2'b00, 24'h0, 24'h0, 1'b1);
    repeat (20) tick();
    applyStimulus(2'b01, 24'hA1, 24'h0, 1'b1);
    tick();
    checkOutput("sat4 valid", outIf4.out_valid,         1);
    checkOutput("sat4 lat0",  outIf4.out_latency[3:0],  15);
    checkOutput("sat4 max0",  maxLatency4[3:0],         15);
    checkOutput("wide lat0",  outIf.out_latency[15:0],  20);
    checkOutput("wide max0",  maxLatency[15:0],         20);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
